// File: rtl/uart_frame_rx.sv
// ============================================================================
//  Module   : uart_frame_rx
//  Brief    : Hunts for a sync byte in a UART byte stream and unpacks RGB444
//             pixels (two per three bytes), then checks a trailing XOR sum.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_rx #(
    parameter int          PANEL_ROWS     = 64,
    parameter int          PANEL_COLS     = 64,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        pix_sync,
    output logic        pix_valid,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int            NPIX        = PANEL_ROWS * PANEL_COLS;
    localparam int            CW          = $clog2(NPIX + 1);
    localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_NPIX      = CW'(NPIX);
    localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_B0     = 3'd1,
        ST_B1     = 3'd2,
        ST_B2     = 3'd3,
        ST_EMIT_B = 3'd4,
        ST_CSUM   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     b0_q, b0_d;
    logic [7:0]     b1_q, b1_d;
    logic [11:0]    pix_b_q, pix_b_d;
    logic [CW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [7:0]     csum_q, csum_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           rx_ready_q, rx_ready_d;
    logic           pix_sync_q, pix_sync_d;
    logic           pix_valid_q, pix_valid_d;
    logic [11:0]    pix_rgb_q, pix_rgb_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_err_q, frame_err_d;
    logic           w_accept;
    logic           w_timer_run;

    assign w_accept    = rx_valid && rx_ready_q;
    assign w_timer_run = state_q inside {ST_B0, ST_B1, ST_B2, ST_CSUM};

    always_comb begin
        state_d      = state_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        pix_b_d      = pix_b_q;
        pix_cnt_d    = pix_cnt_q;
        csum_d       = csum_q;
        timer_d      = timer_q;
        pix_sync_d   = 1'b0;
        pix_valid_d  = 1'b0;
        pix_rgb_d    = pix_rgb_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (w_accept && (rx_data == SYNC_BYTE)) begin
                    state_d   = ST_B0;
                    pix_cnt_d = '0;
                    csum_d    = '0;
                    timer_d   = '0;
                end
            end
            ST_B0: begin
                if (w_accept) begin
                    b0_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (w_accept) begin
                    b1_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (w_accept) begin
                    pix_valid_d = 1'b1;
                    pix_sync_d  = (pix_cnt_q == '0);
                    pix_rgb_d   = {b0_q, b1_q[7:4]};
                    pix_b_d     = {b1_q[3:0], rx_data};
                    pix_cnt_d   = pix_cnt_q + CW'(2);
                    csum_d      = csum_q ^ rx_data;
                    state_d     = ST_EMIT_B;
                end
            end
            ST_EMIT_B: begin
                pix_valid_d = 1'b1;
                pix_rgb_d   = pix_b_q;
                state_d     = (pix_cnt_q == C_NPIX) ? ST_CSUM : ST_B0;
            end
            ST_CSUM: begin
                if (w_accept) begin
                    frame_done_d = (rx_data == csum_q);
                    frame_err_d  = (rx_data != csum_q);
                    state_d      = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // An accepted byte always beats a simultaneous expiry.
        if (w_timer_run) begin
            if (w_accept) begin
                timer_d = '0;
            end else if (timer_q == C_TMO_LAST) begin
                timer_d     = '0;
                state_d     = ST_HUNT;
                frame_err_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    assign rx_ready_d = (state_d != ST_EMIT_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            b0_q         <= '0;
            b1_q         <= '0;
            pix_b_q      <= '0;
            pix_cnt_q    <= '0;
            csum_q       <= '0;
            timer_q      <= '0;
            rx_ready_q   <= 1'b0;
            pix_sync_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_rgb_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            pix_b_q      <= pix_b_d;
            pix_cnt_q    <= pix_cnt_d;
            csum_q       <= csum_d;
            timer_q      <= timer_d;
            rx_ready_q   <= rx_ready_d;
            pix_sync_q   <= pix_sync_d;
            pix_valid_q  <= pix_valid_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign pix_sync   = pix_sync_q;
    assign pix_valid  = pix_valid_q;
    assign pix_rgb    = pix_rgb_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
// ============================================================================
//  Module   : tb_uart_frame_rx
//  Brief    : Directed self-checking bench for uart_frame_rx with a byte-level
//             frame model compared against the outputs every cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_rx;

    localparam int         ROWS = 4;
    localparam int         COLS = 4;
    localparam int         NPIX = ROWS * COLS;
    localparam int         NPAY = 3 * NPIX / 2;
    localparam int         TMO  = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        pix_sync;
    logic        pix_valid;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic        frame_err;

    uart_frame_rx #(
        .PANEL_ROWS     (ROWS),
        .PANEL_COLS     (COLS),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .pix_sync   (pix_sync),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level frame model: tracks position in the frame and predicts outputs.
    logic        e_ready, e_valid, e_sync, e_done, e_err;
    logic [11:0] e_rgb, pend_rgb;
    logic [7:0]  m_sum;
    logic [7:0]  m_buf [3];
    bit          pend_b, in_frame, m_acc;
    int          m_idx, m_idle;

    task automatic model_reset();
        e_ready = 0; e_valid = 0; e_sync = 0; e_done = 0; e_err = 0;
        e_rgb = '0; pend_rgb = '0; pend_b = 0; in_frame = 0; m_acc = 0;
        m_idx = 0; m_idle = 0; m_sum = '0;
    endtask

    task automatic model_step();
        logic        acc;
        logic        nv, ns, nd, ne;
        logic [11:0] nr;
        acc = rx_valid && e_ready;
        m_acc = acc;
        nv = 0; ns = 0; nd = 0; ne = 0; nr = e_rgb;
        if (pend_b) begin
            nv = 1; nr = pend_rgb; pend_b = 0;
        end
        if (acc) begin
            if (!in_frame) begin
                if (rx_data == SYNC) begin
                    in_frame = 1; m_idx = 0; m_sum = '0; m_idle = 0;
                end
            end else if (m_idx < NPAY) begin
                m_buf[m_idx % 3] = rx_data;
                m_sum  = m_sum ^ rx_data;
                m_idx++;
                m_idle = 0;
                if (m_idx % 3 == 0) begin
                    nv = 1;
                    ns = (m_idx == 3);
                    nr = {m_buf[0], m_buf[1][7:4]};
                    pend_b = 1;
                    pend_rgb = {m_buf[1][3:0], m_buf[2]};
                end
            end else begin
                if (rx_data == m_sum) nd = 1; else ne = 1;
                in_frame = 0;
            end
        end else if (in_frame && e_ready) begin
            m_idle++;
            if (m_idle >= TMO) begin
                ne = 1; in_frame = 0;
            end
        end
        e_valid = nv; e_sync = ns; e_rgb = nr; e_done = nd; e_err = ne;
        e_ready = !pend_b;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison plus capture for the literal checks.
    logic [11:0] cap[$];
    int sync_cnt, sync_pos, done_cnt, err_cnt, err_cyc, rdy_low;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rx_ready",   32'(rx_ready),   32'(e_ready));
                chk("pix_valid",  32'(pix_valid),  32'(e_valid));
                chk("pix_sync",   32'(pix_sync),   32'(e_sync));
                chk("pix_rgb",    32'(pix_rgb),    32'(e_rgb));
                chk("frame_done", 32'(frame_done), 32'(e_done));
                chk("frame_err",  32'(frame_err),  32'(e_err));
                if (pix_sync) begin sync_cnt++; sync_pos = cap.size(); end
                if (pix_valid) cap.push_back(pix_rgb);
                if (frame_done) done_cnt++;
                if (frame_err) begin err_cnt++; err_cyc = cyc; end
                if (!rx_ready) rdy_low++;
            end
        end
    end

    logic [7:0] pay [NPAY];
    int         last_acc_cyc;

    task automatic clear_caps();
        cap.delete();
        sync_cnt = 0; sync_pos = -1; done_cnt = 0; err_cnt = 0; err_cyc = 0; rdy_low = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_acc && n < 50);
        if (!m_acc) chk("handshake", 32'd0, 32'd1);
        last_acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends SYNC + payload + checksum; gap_at inserts a 99-cycle pause before that payload byte.
    task automatic send_frame(input logic [7:0] csum, input int gap_at);
        send_byte(SYNC, 0);
        for (int i = 0; i < NPAY; i++) send_byte(pay[i], (i == gap_at) ? 99 : 0);
        send_byte(csum, 0);
        idle(4);
    endtask

    task automatic check_good(input string tag);
        chk({tag, "_npix"}, 32'(cap.size()), 32'd16);
        for (int i = 0; i < NPIX && i < cap.size(); i++)
            chk({tag, "_pix"}, 32'(cap[i]), 32'(12'(i * 12'h111)));
        chk({tag, "_sync_cnt"}, 32'(sync_cnt), 32'd1);
        chk({tag, "_sync_pos"}, 32'(sync_pos), 32'd0);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_stalls"}, 32'(rdy_low), 32'd8);
    endtask

    initial begin
        logic [11:0] pa, pb;
        for (int k = 0; k < NPIX / 2; k++) begin
            pa = 12'((2 * k) * 12'h111);
            pb = 12'((2 * k + 1) * 12'h111);
            pay[3 * k]     = pa[11:4];
            pay[3 * k + 1] = {pa[3:0], pb[11:8]};
            pay[3 * k + 2] = pb[7:0];
        end

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        clear_caps();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        idle(3);

        // Good frame; payload XOR of these pixels is 8'h00.
        clear_caps();
        send_frame(8'h00, -1);
        check_good("good");

        // Leading garbage is dropped before the sync byte.
        clear_caps();
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
        send_frame(8'h00, -1);
        check_good("garbage");

        // Bad checksum.
        clear_caps();
        send_frame(8'h01, -1);
        chk("badcs_npix", 32'(cap.size()), 32'd16);
        chk("badcs_err", 32'(err_cnt), 32'd1);
        chk("badcs_done", 32'(done_cnt), 32'd0);

        // 99-idle-cycle gap: byte lands on the expiry cycle and wins.
        clear_caps();
        send_frame(8'h00, 1);
        check_good("gap");

        // Timeout after sync + 5 payload bytes: only one complete pixel pair.
        clear_caps();
        send_byte(SYNC, 0);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 0);
        idle(150);
        chk("tmo_npix", 32'(cap.size()), 32'd2);
        if (cap.size() >= 2) begin
            chk("tmo_pix0", 32'(cap[0]), 32'h000);
            chk("tmo_pix1", 32'(cap[1]), 32'h111);
        end
        chk("tmo_err", 32'(err_cnt), 32'd1);
        chk("tmo_done", 32'(done_cnt), 32'd0);
        chk("tmo_latency", 32'(err_cyc - last_acc_cyc), 32'd100);
        clear_caps();
        send_frame(8'h00, -1);
        check_good("after_tmo");

        // Reset mid-frame after 10 payload bytes.
        clear_caps();
        send_byte(SYNC, 0);
        for (int i = 0; i < 10; i++) send_byte(pay[i], 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_pix_sync", 32'(pix_sync), 32'd0);
        chk("mid_rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        idle(3);
        clear_caps();
        send_frame(8'h00, -1);
        check_good("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
